// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter (optional parity) with a small write FIFO.
// Line timing advances only on the 16x-baud clken strobe shared with the receiver.
module uart_transmitter #(
  parameter int FIFO_DEPTH = 4,
  parameter int OVERSAMPLE = 16,
  parameter bit PARITY_EN  = 1'b0,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic       clk_50m,
  input  logic       rst_n,
  input  logic       clken,
  input  logic       wr_en,
  input  logic [7:0] din,
  output logic       full,
  output logic       empty,
  output logic       overflow,
  output logic       tx,
  output logic       tx_busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C     = CNT_W'(FIFO_DEPTH);
  localparam logic [3:0]       SAMPLE_LAST = 4'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q;
  logic             push, pop;
  logic [7:0]       head;

  state_t     state_q, state_d;
  logic [3:0] sample_q, sample_d;
  logic [2:0] bitpos_q, bitpos_d;
  logic [7:0] shift_q, shift_d;
  logic       parity_q, parity_d;
  logic       tx_q, tx_d;
  logic       bit_done;

  // full/empty come from the registered count, so a fresh write reaches the FSM a cycle later.
  assign full     = (count_q == DEPTH_C);
  assign empty    = (count_q == '0);
  assign overflow = overflow_q;
  assign push     = wr_en && !full;
  assign head     = mem_q[rd_ptr_q];
  assign tx       = tx_q;
  assign tx_busy  = (state_q != IDLE);
  assign bit_done = clken && (sample_q == SAMPLE_LAST);

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: the storage array has no reset; only pointers and count need one to make it empty.
  always_ff @(posedge clk_50m) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q    <= count_d;
      overflow_q <= wr_en && full;
    end
  end

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    sample_d = sample_q;
    bitpos_d = bitpos_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    pop      = 1'b0;

    if (state_q != IDLE && clken) sample_d = bit_done ? 4'd0 : sample_q + 4'd1;

    case (state_q)
      IDLE: begin
        if (clken && !empty) begin
          pop      = 1'b1;
          shift_d  = head;
          parity_d = ^head ^ PARITY_ODD;
          sample_d = 4'd0;
          state_d  = START;
        end
      end
      START: begin
        if (bit_done) begin
          bitpos_d = 3'd0;
          state_d  = DATA;
        end
      end
      DATA: begin
        if (bit_done) begin
          if (bitpos_q == 3'd7) state_d = PARITY_EN ? PARITY : STOP;
          else                  bitpos_d = bitpos_q + 3'd1;
        end
      end
      PARITY: begin
        if (bit_done) state_d = STOP;
      end
      STOP: begin
        if (bit_done) begin
          // Chain straight into the next start bit while data is waiting.
          if (!empty) begin
            pop      = 1'b1;
            shift_d  = head;
            parity_d = ^head ^ PARITY_ODD;
            state_d  = START;
          end else begin
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[bitpos_d];
      PARITY:  tx_d = parity_d;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sample_q <= 4'd0;
      bitpos_q <= 3'd0;
      shift_q  <= 8'd0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      sample_q <= sample_d;
      bitpos_q <= bitpos_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      tx_q     <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter: random bytes, expected line waveform
// built from the frame rules (start, LSB-first data, optional parity, stop).
module tb_uart_transmitter;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       clken = 1'b0;
  logic [2:0] wr_en = 3'b000;
  logic [7:0] din   = 8'h00;
  logic [2:0] full, empty, ovf, tx, busy;

  int div = 1;
  int n_checks = 0;
  int n_pass   = 0;

  always #10 clk = ~clk;

  // Instance 0: plain 8N1; 1: even parity; 2: odd parity.
  uart_transmitter dut (
    .clk_50m(clk), .rst_n(rst_n), .clken(clken), .wr_en(wr_en[0]), .din(din),
    .full(full[0]), .empty(empty[0]), .overflow(ovf[0]), .tx(tx[0]), .tx_busy(busy[0])
  );
  uart_transmitter #(.PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut_pe (
    .clk_50m(clk), .rst_n(rst_n), .clken(clken), .wr_en(wr_en[1]), .din(din),
    .full(full[1]), .empty(empty[1]), .overflow(ovf[1]), .tx(tx[1]), .tx_busy(busy[1])
  );
  uart_transmitter #(.PARITY_EN(1'b1), .PARITY_ODD(1'b1)) dut_po (
    .clk_50m(clk), .rst_n(rst_n), .clken(clken), .wr_en(wr_en[2]), .din(din),
    .full(full[2]), .empty(empty[2]), .overflow(ovf[2]), .tx(tx[2]), .tx_busy(busy[2])
  );

  // clken strobe: div<=0 holds it low, div==1 holds it high, else one pulse every div cycles.
  initial begin : clken_gen
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      cnt++;
      if (div <= 0) clken = 1'b0;
      else          clken = ((cnt % div) == 0);
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  task automatic push_seq(input int which, input logic [7:0] bytes[$]);
    foreach (bytes[i]) begin
      @(negedge clk);
      wr_en[which] = 1'b1;
      din          = bytes[i];
    end
    @(negedge clk);
    wr_en[which] = 1'b0;
  endtask

  // Waits for the start bit on instance sel, then compares every cycle of the
  // back-to-back frames against a bit list built from the frame format.
  task automatic expect_frames(input string tag, input int sel, input logic [7:0] bytes[$],
                               input bit pe, input bit po, input int dv);
    bit   bits[$];
    bit   mid[$];
    int   bitlen, stride, total, t, errs_tx, errs_busy;
    logic [7:0] dec;
    bitlen = 16 * dv;
    stride = pe ? 11 : 10;
    foreach (bytes[k]) begin
      bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) bits.push_back(bytes[k][i]);
      if (pe) bits.push_back(1'(($countones(bytes[k]) + int'(po)) % 2));
      bits.push_back(1'b1);
    end
    total = bits.size() * bitlen;

    t = 0;
    while (tx[sel] !== 1'b0 && t < 64 * dv + 64) begin
      @(negedge clk);
      t++;
    end
    if (tx[sel] !== 1'b0) begin
      check({tag, "_start_timeout"}, 32'(tx[sel]), 32'd0);
      return;
    end

    errs_tx = 0;
    errs_busy = 0;
    for (int c = 0; c < total; c++) begin
      if (tx[sel] !== bits[c / bitlen]) errs_tx++;
      if (busy[sel] !== 1'b1) errs_busy++;
      if (c % bitlen == bitlen / 2) mid.push_back(tx[sel]);
      @(negedge clk);
    end
    check({tag, "_wave_errs"}, 32'(errs_tx), 32'd0);
    check({tag, "_busy_errs"}, 32'(errs_busy), 32'd0);
    check({tag, "_end_tx"},   32'(tx[sel]),   32'd1);
    check({tag, "_end_busy"}, 32'(busy[sel]), 32'd0);

    foreach (bytes[k]) begin
      for (int i = 0; i < 8; i++) dec[i] = mid[k * stride + 1 + i];
      check($sformatf("%s_byte%0d", tag, k), 32'(dec), 32'(bytes[k]));
      if (pe) check($sformatf("%s_par%0d", tag, k), 32'(mid[k * stride + 9]),
                    32'(($countones(bytes[k]) + int'(po)) % 2));
    end
  endtask

  initial begin : main
    logic [7:0] q[$];
    int errs;

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_tx",       32'(tx[0]),    32'd1);
    check("rst_busy",     32'(busy[0]),  32'd0);
    check("rst_full",     32'(full[0]),  32'd0);
    check("rst_empty",    32'(empty[0]), 32'd1);
    check("rst_overflow", 32'(ovf[0]),   32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single 0x55 frame with clken every cycle; exact start latency.
    q.delete(); q.push_back(8'h55);
    push_seq(0, q);
    check("t1_empty_after_write", 32'(empty[0]), 32'd0);
    check("t1_tx_still_idle",     32'(tx[0]),    32'd1);
    @(negedge clk);
    check("t1_tx_fall",     32'(tx[0]),    32'd0);
    check("t1_busy_rise",   32'(busy[0]),  32'd1);
    check("t1_empty_after_pop", 32'(empty[0]), 32'd1);
    expect_frames("t1", 0, q, 1'b0, 1'b0, 1);

    // Two back-to-back frames: one continuous busy window.
    q.delete(); q.push_back(8'hA5); q.push_back(8'h3C);
    push_seq(0, q);
    expect_frames("t2", 0, q, 1'b0, 1'b0, 1);
    check("t2_empty", 32'(empty[0]), 32'd1);

    // Fill with clken held low: 4 accepted, 5th dropped with an overflow pulse.
    div = 0;
    repeat (2) @(negedge clk);
    q.delete();
    for (int i = 0; i < 5; i++) q.push_back(8'($urandom));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 3) check("t3_not_full_at_3", 32'(full[0]), 32'd0);
      if (i == 4) begin
        check("t3_full_at_4",   32'(full[0]), 32'd1);
        check("t3_no_ovf_yet",  32'(ovf[0]),  32'd0);
      end
      wr_en[0] = 1'b1;
      din      = q[i];
    end
    @(negedge clk);
    wr_en[0] = 1'b0;
    check("t3_ovf_pulse",  32'(ovf[0]),  32'd1);
    check("t3_still_full", 32'(full[0]), 32'd1);
    @(negedge clk);
    check("t3_ovf_clear",  32'(ovf[0]),  32'd0);
    check("t3_frozen_tx",  32'(tx[0]),   32'd1);
    check("t3_frozen_busy", 32'(busy[0]), 32'd0);
    void'(q.pop_back());
    div = 1;
    expect_frames("t3", 0, q, 1'b0, 1'b0, 1);
    check("t3_empty", 32'(empty[0]), 32'd1);

    // Parity instances, even then odd.
    q.delete(); q.push_back(8'h07); q.push_back(8'($urandom));
    push_seq(1, q);
    expect_frames("t4_even", 1, q, 1'b1, 1'b0, 1);
    push_seq(2, q);
    expect_frames("t4_odd", 2, q, 1'b1, 1'b1, 1);

    // Slow strobe: each bit is 16*27 clk.
    div = 27;
    q.delete(); q.push_back(8'($urandom));
    push_seq(0, q);
    expect_frames("t5", 0, q, 1'b0, 1'b0, 27);

    // Reset mid DATA of 0xFF with two bytes queued.
    div = 1;
    repeat (2) @(negedge clk);
    q.delete(); q.push_back(8'hFF); q.push_back(8'($urandom)); q.push_back(8'($urandom));
    push_seq(0, q);
    errs = 0;
    while (tx[0] !== 1'b0 && errs < 100) begin
      @(negedge clk);
      errs++;
    end
    repeat (16 * 3) @(negedge clk);
    check("t6_busy_before_rst", 32'(busy[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_tx",    32'(tx[0]),    32'd1);
    check("t6_rst_busy",  32'(busy[0]),  32'd0);
    check("t6_rst_empty", 32'(empty[0]), 32'd1);
    check("t6_rst_full",  32'(full[0]),  32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    errs = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (tx[0] !== 1'b1 || busy[0] !== 1'b0) errs++;
    end
    check("t6_idle_after_rst_errs", 32'(errs), 32'd0);
    q.delete(); q.push_back(8'($urandom));
    push_seq(0, q);
    expect_frames("t6_recover", 0, q, 1'b0, 1'b0, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
